// File: rtl/peripheral_apb4_initiator.sv
// APB4 initiator: turns single-beat valid/ready commands into APB transfers
// and returns one response per command, with an optional PREADY timeout.
module peripheral_apb4_initiator #(
  parameter int PADDR_SIZE = 4,
  parameter int PDATA_SIZE = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [PADDR_SIZE-1:0]   cmd_addr,
  input  logic [PDATA_SIZE-1:0]   cmd_wdata,
  input  logic [PDATA_SIZE/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [PDATA_SIZE-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [PADDR_SIZE-1:0]   PADDR,
  output logic [PDATA_SIZE-1:0]   PWDATA,
  output logic [PDATA_SIZE/8-1:0] PSTRB,
  input  logic [PDATA_SIZE-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int STRB_SIZE = PDATA_SIZE / 8;
  localparam int CNT_SIZE  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_SIZE-1:0] CNT_MAX   = '1;
  localparam logic [CNT_SIZE-1:0] CNT_LIMIT = CNT_SIZE'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                  state_q, state_d;
  logic [CNT_SIZE-1:0]     cnt_q, cnt_d, cnt_inc;
  logic                    psel_d, penable_d, pwrite_d;
  logic [PADDR_SIZE-1:0]   paddr_d;
  logic [PDATA_SIZE-1:0]   pwdata_d, rsp_rdata_d;
  logic [STRB_SIZE-1:0]    pstrb_d;
  logic                    rsp_valid_d, rsp_err_d, rsp_timeout_d;

  assign cmd_ready = (state_q == IDLE);
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_SIZE'(1);

  // Next-state logic also computes the next value of every registered output,
  // so the bus and response ports never glitch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    psel_d        = PSEL;
    penable_d     = PENABLE;
    pwrite_d      = PWRITE;
    paddr_d       = PADDR;
    pwdata_d      = PWDATA;
    pstrb_d       = PSTRB;
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d   = SETUP;
          cnt_d     = '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_write ? cmd_wdata : '0;
          pstrb_d   = cmd_write ? cmd_strb : '0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (PREADY) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = PWRITE ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
          // A completing PREADY takes priority over reaching the limit.
          if ((TIMEOUT != 0) && (cnt_inc == CNT_LIMIT)) begin
            state_d       = RESP;
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      PSEL        <= psel_d;
      PENABLE     <= penable_d;
      PWRITE      <= pwrite_d;
      PADDR       <= paddr_d;
      PWDATA      <= pwdata_d;
      PSTRB       <= pstrb_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_peripheral_apb4_initiator.sv
// Bench for peripheral_apb4_initiator: memory-backed APB responder with
// configurable wait states, and a per-command reference model of responses.
module tb_peripheral_apb4_initiator;

  localparam int TO = 4;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [3:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic [0:0] cmd_strb = '0;
  logic       rsp_valid, rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic       rsp_err, rsp_timeout;
  logic       PSEL, PENABLE, PWRITE;
  logic [3:0] PADDR;
  logic [7:0] PWDATA;
  logic [0:0] PSTRB;
  logic [7:0] PRDATA = '0;
  logic       PREADY = 1'b0, PSLVERR = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  int   cfg_waits = 0;
  logic cfg_err = 1'b0, cfg_stuck = 1'b0;
  int   acc_cnt = 0;
  logic [7:0] resp_mem [16] = '{default: 8'h00};
  logic [7:0] exp_mem  [16] = '{default: 8'h00};

  peripheral_apb4_initiator #(.PADDR_SIZE(4), .PDATA_SIZE(8), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // Responder: completes after cfg_waits low-PREADY cycles; garbage outside completion.
  always @(negedge PCLK) begin
    if (PSEL && PENABLE) begin
      PREADY = !cfg_stuck && (acc_cnt >= cfg_waits);
      acc_cnt++;
    end else begin
      PREADY  = 1'b0;
      acc_cnt = 0;
    end
    PRDATA  = (PREADY && !PWRITE) ? resp_mem[PADDR] : 8'($urandom);
    PSLVERR = PREADY ? cfg_err : 1'($urandom);
  end

  always @(posedge PCLK)
    if (PSEL && PENABLE && PREADY && PWRITE && PSTRB[0]) resp_mem[PADDR] <= PWDATA;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  // Drives one command and gathers observations; callers do the comparisons.
  task automatic run_txn(input logic wr, input logic [3:0] addr, input logic [7:0] wd,
                         input logic st, input int waits, input logic err, input logic stuck,
                         input int hold, input logic keep_valid,
                         output int lat, output int pen, output int acc_wait,
                         output logic [7:0] rd, output logic e, output logic to,
                         output logic bus_ok, output logic hold_ok);
    int n;
    cfg_waits = waits; cfg_err = err; cfg_stuck = stuck;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
    rsp_ready = (hold == 0);
    acc_wait = 0;
    while (!cmd_ready && acc_wait < 50) begin
      @(negedge PCLK);
      acc_wait++;
    end
    n = 0; pen = 0; lat = -1; bus_ok = 1'b1; hold_ok = 1'b1;
    while (lat < 0 && n < 60) begin
      @(negedge PCLK);
      n++;
      if (n == 1 && !keep_valid) cmd_valid = 1'b0;
      if (PENABLE) pen++;
      if (PENABLE && !PSEL) bus_ok = 1'b0;
      if (n == 1 && (PSEL !== 1'b1 || PENABLE !== 1'b0)) bus_ok = 1'b0;
      if (PSEL && (PADDR !== addr || PWRITE !== wr ||
                   PWDATA !== (wr ? wd : 8'h00) || PSTRB !== (wr ? st : 1'b0)))
        bus_ok = 1'b0;
      if (rsp_valid) begin
        lat = n;
        if (PSEL || PENABLE) bus_ok = 1'b0;
      end
    end
    rd = rsp_rdata; e = rsp_err; to = rsp_timeout;
    for (int h = 0; h < hold; h++) begin
      if (h > 0) @(negedge PCLK);
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== e || rsp_timeout !== to ||
          cmd_ready !== 1'b0 || PSEL !== 1'b0)
        hold_ok = 1'b0;
    end
    rsp_ready = 1'b1;
  endtask

  task automatic test_reset();
    n_checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || rsp_valid !== 1'b0)
      $display("[TB] FAIL reset_ctrl got=%b%b%b exp=000", PSEL, PENABLE, rsp_valid); else n_pass++;
    PRESETn = 1'b1;
    @(negedge PCLK);
    n_checks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL reset_cmd_ready got=%b exp=1", cmd_ready); else n_pass++;
    n_checks++; if ({PWRITE, PADDR, PWDATA, PSTRB} !== 14'h0)
      $display("[TB] FAIL reset_bus got=%h exp=0", {PWRITE, PADDR, PWDATA, PSTRB}); else n_pass++;
    n_checks++; if ({rsp_rdata, rsp_err, rsp_timeout} !== 10'h0)
      $display("[TB] FAIL reset_rsp got=%h exp=0", {rsp_rdata, rsp_err, rsp_timeout}); else n_pass++;
  endtask

  task automatic test_write_zero_wait();
    int lat, pen, aw; logic [7:0] rd; logic e, to, bok, hok;
    run_txn(1'b1, 4'd2, 8'hA5, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, lat, pen, aw, rd, e, to, bok, hok);
    exp_mem[2] = 8'hA5;
    n_checks++; if (lat !== 3) $display("[TB] FAIL wr_latency got=%0d exp=3", lat); else n_pass++;
    n_checks++; if (pen !== 1) $display("[TB] FAIL wr_penable_cycles got=%0d exp=1", pen); else n_pass++;
    n_checks++; if (bok !== 1'b1) $display("[TB] FAIL wr_bus got=%b exp=1", bok); else n_pass++;
    n_checks++; if ({rd, e, to} !== 10'h0) $display("[TB] FAIL wr_rsp got=%h exp=0", {rd, e, to}); else n_pass++;
  endtask

  task automatic test_read();
    int lat, pen, aw; logic [7:0] rd; logic e, to, bok, hok;
    run_txn(1'b0, 4'd2, 8'h5A, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, lat, pen, aw, rd, e, to, bok, hok);
    n_checks++; if (bok !== 1'b1) $display("[TB] FAIL rd_bus_zero_wdata got=%b exp=1", bok); else n_pass++;
    n_checks++; if (rd !== exp_mem[2]) $display("[TB] FAIL rd_data got=%h exp=%h", rd, exp_mem[2]); else n_pass++;
    n_checks++; if ({e, to} !== 2'b00) $display("[TB] FAIL rd_err got=%b exp=00", {e, to}); else n_pass++;
  endtask

  task automatic test_wait_err();
    int lat, pen, aw; logic [7:0] rd; logic e, to, bok, hok;
    run_txn(1'b0, 4'd2, 8'h00, 1'b0, 3, 1'b1, 1'b0, 0, 1'b0, lat, pen, aw, rd, e, to, bok, hok);
    n_checks++; if (pen !== 4) $display("[TB] FAIL wait_penable_cycles got=%0d exp=4", pen); else n_pass++;
    n_checks++; if (lat !== 6) $display("[TB] FAIL wait_latency got=%0d exp=6", lat); else n_pass++;
    n_checks++; if ({e, to} !== 2'b10) $display("[TB] FAIL wait_err got=%b exp=10", {e, to}); else n_pass++;
    n_checks++; if (rd !== exp_mem[2]) $display("[TB] FAIL wait_rdata got=%h exp=%h", rd, exp_mem[2]); else n_pass++;
  endtask

  task automatic test_timeout();
    int lat, pen, aw; logic [7:0] rd; logic e, to, bok, hok;
    run_txn(1'b0, 4'd7, 8'h00, 1'b0, 0, 1'b0, 1'b1, 0, 1'b0, lat, pen, aw, rd, e, to, bok, hok);
    n_checks++; if (pen !== TO) $display("[TB] FAIL to_penable_cycles got=%0d exp=%0d", pen, TO); else n_pass++;
    n_checks++; if (lat !== 2 + TO) $display("[TB] FAIL to_latency got=%0d exp=%0d", lat, 2 + TO); else n_pass++;
    n_checks++; if (bok !== 1'b1) $display("[TB] FAIL to_bus got=%b exp=1", bok); else n_pass++;
    n_checks++; if ({rd, e, to} !== {8'h00, 2'b11}) $display("[TB] FAIL to_rsp got=%h exp=003", {rd, e, to}); else n_pass++;
    cfg_stuck = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat, pen, aw, n; logic [7:0] rd; logic e, to, bok, hok;
    run_txn(1'b1, 4'd5, 8'h3C, 1'b1, 0, 1'b0, 1'b0, 5, 1'b1, lat, pen, aw, rd, e, to, bok, hok);
    exp_mem[5] = 8'h3C;
    n_checks++; if (hok !== 1'b1) $display("[TB] FAIL bp_hold_stable got=%b exp=1", hok); else n_pass++;
    @(negedge PCLK);
    n_checks++; if ({cmd_ready, rsp_valid} !== 2'b10)
      $display("[TB] FAIL bp_idle_after_hs got=%b exp=10", {cmd_ready, rsp_valid}); else n_pass++;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    n_checks++; if ({PSEL, PENABLE} !== 2'b10)
      $display("[TB] FAIL bp_next_accept got=%b exp=10", {PSEL, PENABLE}); else n_pass++;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge PCLK); n++; end
    n_checks++; if ({rsp_valid, rsp_err} !== 2'b10)
      $display("[TB] FAIL bp_second_rsp got=%b exp=10", {rsp_valid, rsp_err}); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat, pen, aw, n; logic [7:0] rd; logic e, to, bok, hok; logic seen;
    cfg_stuck = 1'b1;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd9; cmd_wdata = 8'hEE; cmd_strb = 1'b1;
    n = 0;
    while (!PENABLE && n < 20) begin @(negedge PCLK); n++; end
    cmd_valid = 1'b0;
    #2 PRESETn = 1'b0;
    #1;
    n_checks++; if ({PSEL, PENABLE, rsp_valid} !== 3'b000)
      $display("[TB] FAIL rst_mid_async got=%b exp=000", {PSEL, PENABLE, rsp_valid}); else n_pass++;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    cfg_stuck = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      if (rsp_valid || PSEL) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) $display("[TB] FAIL rst_mid_no_rsp got=%b exp=0", seen); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL rst_mid_ready got=%b exp=1", cmd_ready); else n_pass++;
    run_txn(1'b1, 4'd9, 8'h42, 1'b1, 1, 1'b0, 1'b0, 0, 1'b0, lat, pen, aw, rd, e, to, bok, hok);
    exp_mem[9] = 8'h42;
    n_checks++; if (lat !== 4 || {e, to} !== 2'b00)
      $display("[TB] FAIL rst_mid_after got=%0d/%b exp=4/00", lat, {e, to}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat, pen, aw; logic [7:0] rd; logic e, to, bok, hok;
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b0, 4'(i), 8'h00, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, lat, pen, aw, rd, e, to, bok, hok);
      n_checks++; if (i > 0 && aw !== 0) $display("[TB] FAIL b2b_accept_wait got=%0d exp=0", aw);
      else if (lat !== 3) $display("[TB] FAIL b2b_latency got=%0d exp=3", lat); else n_pass++;
      n_checks++; if (rd !== exp_mem[i]) $display("[TB] FAIL b2b_rdata got=%h exp=%h", rd, exp_mem[i]); else n_pass++;
    end
  endtask

  task automatic test_random();
    int lat, pen, aw, waits, elat, epen; logic [7:0] rd, wd, erd; logic e, to, bok, hok;
    logic wr, st, err, stuck; logic [3:0] addr;
    for (int i = 0; i < 30; i++) begin
      wr = 1'($urandom); addr = 4'($urandom); wd = 8'($urandom); st = 1'($urandom);
      waits = $urandom_range(0, TO - 1); err = ($urandom_range(0, 3) == 0);
      stuck = ($urandom_range(0, 7) == 0);
      run_txn(wr, addr, wd, st, waits, err, stuck, 0, 1'b0, lat, pen, aw, rd, e, to, bok, hok);
      elat = stuck ? 2 + TO : 3 + waits;
      epen = stuck ? TO : waits + 1;
      erd  = (stuck || wr) ? 8'h00 : exp_mem[addr];
      if (wr && st && !stuck) exp_mem[addr] = wd;
      n_checks++; if (lat !== elat) $display("[TB] FAIL rnd_latency i=%0d got=%0d exp=%0d", i, lat, elat); else n_pass++;
      n_checks++; if (pen !== epen) $display("[TB] FAIL rnd_penable i=%0d got=%0d exp=%0d", i, pen, epen); else n_pass++;
      n_checks++; if (bok !== 1'b1) $display("[TB] FAIL rnd_bus i=%0d got=%b exp=1", i, bok); else n_pass++;
      n_checks++; if (rd !== erd) $display("[TB] FAIL rnd_rdata i=%0d got=%h exp=%h", i, rd, erd); else n_pass++;
      n_checks++; if ({e, to} !== {stuck | err, stuck})
        $display("[TB] FAIL rnd_err i=%0d got=%b exp=%b", i, {e, to}, {stuck | err, stuck}); else n_pass++;
      cfg_stuck = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge PCLK);
    test_reset();
    test_write_zero_wait();
    test_read();
    test_wait_err();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (3) @(negedge PCLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
